mem_responder: RTL and testbench

Word-addressed, synthesizable memory model that answers the CPU datapath's memory port: it accepts `mem_read`/`mem_write` requests on the MAR address and data-out register, waits a programmable number of cycles, then pulses `mem_resp` with read data or a committed byte-enabled write. It sits on the memory side of the core's single memory interface. Used in simulation and FPGA bring-up in place of the course memory.

---
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory model with programmable response latency
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] r_idx;
  logic          r_wr;
  logic          r_bad;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          live_bad;
  logic [AW-1:0] s_idx;
  logic          s_wr;
  logic          s_bad;
  logic [3:0]    s_be;
  logic [31:0]   s_wdata;
  logic          enter_resp;
  logic          commit;

  assign req      = mem_read | mem_write;
  assign live_bad = (|mem_address[31:AW+2]) | (mem_read & mem_write);

  // With LATENCY=1 the response is produced from IDLE, before the request registers hold it.
  always_comb begin
    if (state == IDLE) begin
      s_idx   = mem_address[AW+1:2];
      s_wr    = mem_write;
      s_bad   = live_bad;
      s_be    = mem_byte_enable;
      s_wdata = mem_wdata;
    end else begin
      s_idx   = r_idx;
      s_wr    = r_wr;
      s_bad   = r_bad;
      s_be    = r_be;
      s_wdata = r_wdata;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    case (state)
      IDLE:    enter_resp = req & LAT_ONE;
      WAIT:    enter_resp = req & (cnt <= 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  assign commit = enter_resp & ~rst & s_wr & ~s_bad;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (s_be[i]) mem[s_idx][8*i +: 8] <= s_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_resp <= 1'b0;
      mem_err  <= 1'b0;
      if (state == IDLE && req) begin
        r_idx   <= mem_address[AW+1:2];
        r_wr    <= mem_write;
        r_bad   <= live_bad;
        r_be    <= mem_byte_enable;
        r_wdata <= mem_wdata;
      end
      if (enter_resp) begin
        state    <= RESP;
        cnt      <= 4'd0;
        mem_resp <= 1'b1;
        mem_err  <= s_bad;
        // Dual-op requests count as writes, so they leave the read data untouched.
        if (!s_wr) mem_rdata <= s_bad ? 32'h0 : mem[s_idx];
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (!req) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder at latencies 1..4
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       rd_v, wr_v;
  logic [3:0][3:0]  be_v;
  logic [3:0][31:0] addr_v, wd_v;
  wire  [3:0][31:0] rdata_v;
  wire  [3:0]       resp_v, err_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .mem_read(rd_v[g]), .mem_write(wr_v[g]),
      .mem_byte_enable(be_v[g]), .mem_address(addr_v[g]), .mem_wdata(wd_v[g]),
      .mem_rdata(rdata_v[g]), .mem_resp(resp_v[g]), .mem_err(err_v[g])
    );
  end

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  logic [31:0] mm [4][256];
  bit          mk [4][256];
  int          pend_cyc [4];
  bit          pend_err [4], pend_upd [4], pend_known [4];
  logic [31:0] pend_data [4];
  logic [31:0] hold [4];
  bit          hk [4];
  int          last_resp [4], resp_cnt [4];
  bit          last_err [4];
  int          sweep_k = -1;
  int          rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        bit e;
        e = (pend_cyc[k] == cyc);
        chk("resp", k, 32'(resp_v[k]), 32'(e));
        if (e) begin
          chk("err", k, 32'(err_v[k]), 32'(pend_err[k]));
          last_resp[k] = cyc;
          last_err[k]  = err_v[k];
          resp_cnt[k]++;
          if (k == sweep_k) rq.push_back(cyc);
          if (pend_upd[k]) begin
            hold[k] = pend_data[k];
            hk[k]   = pend_known[k];
          end
        end else begin
          chk("err_idle", k, 32'(err_v[k]), 32'h0);
        end
        if (hk[k]) chk("rdata", k, rdata_v[k], hold[k]);
      end
    end
  end

  // mode 0: normal, 1: drop request after one cycle, 2: reset one cycle after the request
  task automatic req(input int k, input bit rd, input bit wr, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] d, input int mode, output int t0);
    int  lat = k + 1;
    bit  oor = (a[31:10] != 0);
    int  idx = int'(a[9:2]);
    t0 = cyc;
    rd_v[k] = rd; wr_v[k] = wr; be_v[k] = be; addr_v[k] = a; wd_v[k] = d;
    if (mode == 0) begin
      pend_cyc[k]   = t0 + lat;
      pend_err[k]   = oor || (rd && wr);
      pend_upd[k]   = rd && !wr;
      pend_data[k]  = oor ? 32'h0 : mm[k][idx];
      pend_known[k] = oor ? 1'b1 : mk[k][idx];
      if (wr && !rd && !oor) begin
        for (int i = 0; i < 4; i++) if (be[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
        if (be == 4'hF) mk[k][idx] = 1'b1;
      end
      repeat (lat + 1) @(posedge clk);
      #1;
      rd_v[k] = 0; wr_v[k] = 0;
    end else begin
      @(posedge clk); #1;
      if (mode == 1) begin
        rd_v[k] = 0; wr_v[k] = 0;
      end else begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0; rd_v[k] = 0; wr_v[k] = 0;
        for (int j = 0; j < 4; j++) begin hold[j] = 32'h0; hk[j] = 1'b1; end
      end
      repeat (lat + 2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, c0;
    rst = 1; rd_v = 0; wr_v = 0; be_v = '0; addr_v = '0; wd_v = '0;
    for (int k = 0; k < 4; k++) begin
      pend_cyc[k] = -1; resp_cnt[k] = 0; last_resp[k] = -1;
      for (int w = 0; w < 256; w++) mk[k][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      hold[k] = 32'h0; hk[k] = 1'b1;
      chk("rst_rdata", k, rdata_v[k], 32'h0);
      chk("rst_resp", k, 32'(resp_v[k]), 32'h0);
    end
    chk_en = 1;

    // Directed cases at LATENCY=2.
    req(1, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, t);
    chk("wr_latency", 1, 32'(last_resp[1] - t), 32'd2);
    req(1, 1, 0, 4'hF, 32'h10, 32'h0, 0, t);
    chk("rd_latency", 1, 32'(last_resp[1] - t), 32'd2);
    chk("rd_beef", 1, rdata_v[1], 32'hDEADBEEF);
    chk("rd_beef_err", 1, 32'(last_err[1]), 32'h0);
    req(1, 0, 1, 4'hF, 32'h20, 32'h11223344, 0, t);
    req(1, 0, 1, 4'h8, 32'h20, 32'hAA000000, 0, t);
    req(1, 1, 0, 4'h0, 32'h20, 32'h0, 0, t);
    chk("byte_lane", 1, rdata_v[1], 32'hAA223344);
    req(1, 0, 1, 4'h0, 32'h20, 32'h12345678, 0, t);
    chk("be0_err", 1, 32'(last_err[1]), 32'h0);
    req(1, 1, 0, 4'h0, 32'h20, 32'h0, 0, t);
    chk("be0_keep", 1, rdata_v[1], 32'hAA223344);
    req(1, 0, 1, 4'hF, 32'h0, 32'h0BADF00D, 0, t);
    req(1, 1, 0, 4'h0, 32'h400, 32'h0, 0, t);
    chk("oor_rd_data", 1, rdata_v[1], 32'h0);
    chk("oor_rd_err", 1, 32'(last_err[1]), 32'h1);
    req(1, 0, 1, 4'hF, 32'h400, 32'hFFFFFFFF, 0, t);
    chk("oor_wr_err", 1, 32'(last_err[1]), 32'h1);
    req(1, 1, 0, 4'h0, 32'h0, 32'h0, 0, t);
    chk("oor_no_alias", 1, rdata_v[1], 32'h0BADF00D);
    req(1, 1, 1, 4'hF, 32'h20, 32'h0, 0, t);
    chk("both_err", 1, 32'(last_err[1]), 32'h1);
    chk("both_rdata", 1, rdata_v[1], 32'h0BADF00D);
    req(1, 1, 0, 4'h0, 32'h20, 32'h0, 0, t);
    chk("both_no_write", 1, rdata_v[1], 32'hAA223344);

    // Abort cases at LATENCY=3.
    req(2, 0, 1, 4'hF, 32'h30, 32'h12345678, 0, t);
    c0 = resp_cnt[2];
    req(2, 0, 1, 4'hF, 32'h30, 32'h5555AAAA, 1, t);
    chk("abort_no_resp", 2, 32'(resp_cnt[2]), 32'(c0));
    req(2, 1, 0, 4'h0, 32'h30, 32'h0, 0, t);
    chk("abort_old", 2, rdata_v[2], 32'h12345678);
    c0 = resp_cnt[2];
    req(2, 0, 1, 4'hF, 32'h30, 32'h5555AAAA, 2, t);
    chk("rst_no_resp", 2, 32'(resp_cnt[2]), 32'(c0));
    req(2, 1, 0, 4'h0, 32'h30, 32'h0, 0, t);
    chk("rst_old", 2, rdata_v[2], 32'h12345678);

    // Back-to-back spacing at LATENCY=1 and 4.
    for (int s = 0; s < 2; s++) begin
      int k = (s == 0) ? 0 : 3;
      req(k, 0, 1, 4'hF, 32'h40, 32'hCAFEF00D, 0, t);
      sweep_k = k;
      rq.delete();
      req(k, 1, 0, 4'h0, 32'h40, 32'h0, 0, t);
      chk("sweep_rd1", k, rdata_v[k], 32'hCAFEF00D);
      req(k, 0, 1, 4'hF, 32'h40, 32'h12121212, 0, t);
      chk("sweep_hold", k, rdata_v[k], 32'hCAFEF00D);
      req(k, 1, 0, 4'h0, 32'h40, 32'h0, 0, t);
      chk("sweep_rd2", k, rdata_v[k], 32'h12121212);
      chk("sweep_count", k, 32'(rq.size()), 32'd3);
      if (rq.size() == 3) begin
        chk("sweep_gap1", k, 32'(rq[1] - rq[0]), 32'(k + 2));
        chk("sweep_gap2", k, 32'(rq[2] - rq[1]), 32'(k + 2));
      end
      sweep_k = -1;
    end

    // Randomized traffic on every latency.
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 16; w++) req(k, 0, 1, 4'hF, 32'(w << 2), $urandom, 0, t);
      for (int n = 0; n < 50; n++) begin
        int          op = $urandom_range(0, 9);
        logic [31:0] a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        logic [3:0]  be = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
        if (op <= 3 || (op == 9 && k == 0)) req(k, 1, 0, be, a, $urandom, 0, t);
        else if (op <= 7) req(k, 0, 1, be, a, $urandom, 0, t);
        else if (op == 8) req(k, 1, 1, be, a, $urandom, 0, t);
        else req(k, 0, 1, be, a, $urandom, 1, t);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
